hazard_control: RTL and testbench
=================================

# hazard_control

Interlock and sequencing controller for the 5-stage pipeline (IF, ID/IR1, RF/IR2, EX/IR3, WB/IR4). Decodes the instruction held in IR1 and tracks a tag scoreboard that mirrors the in-flight instructions in IR2–IR4. From these it generates the PC/IR1 write enables, nop-bubble insertion, branch squash and the STOP drain/halt sequence. It has no forwarding: every RAW and flag hazard is resolved by stalling.

## Interface
- NUM_SLOTS, 3, number of in-flight slots tracked (IR2, IR3, IR4)
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- IR1  in  8  instruction in decode; [7:6]=R1 field, [5:4]=R2 field, [3:0]=opcode
- IR1Valid  in  1  IR1 holds a real instruction (0 after reset/flush)
- BranchTaken  in  1  branch in EX (IR3) resolved taken this cycle
- PCWrite  out  1  advance PC
- IR1Write  out  1  load IR1 from fetch
- BubbleSel  out  1  IR2 loads nop (4'b1010) instead of IR1
- FlushIR1  out  1  clear IR1Valid next edge
- Stall  out  1  hazard stall active this cycle
- Halted  out  1  pipeline drained after STOP

## Operation
- Decode of IR1 (valid only when IR1Valid=1):
  - load 0000: reads R2, writes R1 field.
  - store 0010: reads R1, R2; no write.
  - add 0100, sub 0110, nand 1000: read R1, R2; write R1 field; set flags.
  - ori [2:0]=111: reads and writes register 1; sets flags.
  - shift [2:0]=011: reads and writes R1 field; sets flags.
  - bz 0101, bnz 1001, bpz 1101: read flags only.
  - stop 0001: no operands.
  - nop 1010, any other opcode: no operands.
- Scoreboard: one tag per slot {wr_valid, wr_reg[1:0], sets_flags}. It shifts every cycle (slot0→slot1→slot2→retired). Slot0 loads the IR1 tag on issue, or a zero tag on a bubble or flush. The back end never stalls.
- Hazard (combinational): raised when IR1Valid and either:
  - a source register equals wr_reg of any slot with wr_valid; or
  - IR1 is a branch and any slot has sets_flags.
- FSM states RUN, DRAIN, HALTED; reset state is RUN.
- RUN, priority order:
  1. BranchTaken: FlushIR1=1, BubbleSel=1, PCWrite=1, IR1Write=1, Stall=0. The branch target is fetched and the hazard is ignored.
  2. Hazard: Stall=1, PCWrite=0, IR1Write=0, BubbleSel=1.
  3. IR1 is stop: issue stop as nop (BubbleSel=1), PCWrite=0, IR1Write=0, go to DRAIN.
  4. Otherwise: issue; PCWrite=1, IR1Write=1, BubbleSel=0.
- DRAIN:
  - PCWrite=0, IR1Write=0, BubbleSel=1.
  - Go to HALTED when all slot tags are zero and BranchTaken=0.
  - BranchTaken in DRAIN (a branch older than stop): FlushIR1=1, PCWrite=1, IR1Write=1, return to RUN.
- HALTED: Halted=1, all enables 0, BubbleSel=1. Left only by reset.
- Reset (any state, mid-stall or mid-drain):
  - Outputs: PCWrite=0, IR1Write=0, BubbleSel=1, FlushIR1=1, Stall=0, Halted=0.
  - Scoreboard cleared; FSM to RUN.

## Timing
- All outputs are combinational from IR1, IR1Valid, BranchTaken, scoreboard and FSM state; they are valid in the same cycle.
- Scoreboard and FSM update on the rising clock edge.
- Dependent back-to-back instructions stall exactly 3 cycles, the 4th cycle issues. The writer then has completed WB, since a write is not readable in its own WB cycle.
- One intervening independent instruction gives 2 stall cycles; two give 1; three give 0.
- A branch after a flag setter stalls the same way.
- Flush: the instruction in IR1 and the one entering IR2 are squashed; 2-cycle branch penalty.
- HALTED is asserted 3 cycles after stop enters DRAIN, or 1 cycle after the last older instruction retires.

## Structure
- Shared package proc_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND, OP_ORI3, OP_SHIFT3, OP_BZ, OP_BNZ, OP_BPZ, OP_STOP, OP_NOP);
  - the tag struct/width;
  - FSM state encoding;
  - NOP_INSTR=8'h0A.
- Sub-module hazard_scoreboard: NUM_SLOTS-deep tag shift register with sync reset and a per-register/flag match output. Decode, FSM and output logic live in hazard_control.

## Test plan
- Reset mid-stall: assert reset while Stall=1 → same cycle PCWrite=0, BubbleSel=1, FlushIR1=1. Next cycle all tags zero, FSM=RUN, Halted=0.
- RAW load→add: issue load R2,(R3) = 8'b10_11_0000, then IR1 = add R1,R2 = 8'b01_10_0100 → Stall=1 for 3 cycles with BubbleSel=1; 4th cycle PCWrite=1, BubbleSel=0.
- Partial distance: add R1,R2; nop; add R3,R1 → 2 stall cycles. Independent add R3,R0 (8'b11_00_0100) after add R1,R2 → 0 stalls.
- Flag hazard: ori then bz → 3 stalls. store then bz → 0 stalls.
- Branch priority: BranchTaken=1 while IR1 holds a hazarding add → Stall=0, FlushIR1=1, PCWrite=1, IR1Write=1, slot0 tag zero.
- STOP: stop (8'h01) with a store ahead → DRAIN with PCWrite=0. Halted=1 once slots are empty. Halted stays 1 for 10+ cycles until reset. A BranchTaken during DRAIN returns the FSM to RUN with Halted=0.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, scoreboard tag, FSM encoding and IR1 decode
package proc_pkg;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_NAND   = 4'b1000;
  localparam logic [2:0] OP_ORI3   = 3'b111;
  localparam logic [2:0] OP_SHIFT3 = 3'b011;
  localparam logic [3:0] OP_BZ     = 4'b0101;
  localparam logic [3:0] OP_BNZ    = 4'b1001;
  localparam logic [3:0] OP_BPZ    = 4'b1101;
  localparam logic [3:0] OP_STOP   = 4'b0001;
  localparam logic [3:0] OP_NOP    = 4'b1010;

  localparam logic [7:0] NOP_INSTR = 8'h0A;

  typedef struct packed {
    logic       wr_valid;
    logic [1:0] wr_reg;
    logic       sets_flags;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       rd1_en;
    logic [1:0] rd1_reg;
    logic       rd2_en;
    logic [1:0] rd2_reg;
    logic       is_branch;
    logic       is_stop;
    tag_t       tag;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] instr);
    dec_t d;
    d         = '0;
    d.rd1_reg = instr[7:6];
    d.rd2_reg = instr[5:4];
    // ori always targets register 1 regardless of the R1 field
    if (instr[2:0] == OP_ORI3) begin
      d.rd1_en         = 1'b1;
      d.rd1_reg        = 2'd1;
      d.tag.wr_valid   = 1'b1;
      d.tag.wr_reg     = 2'd1;
      d.tag.sets_flags = 1'b1;
    end else if (instr[2:0] == OP_SHIFT3) begin
      d.rd1_en         = 1'b1;
      d.tag.wr_valid   = 1'b1;
      d.tag.wr_reg     = instr[7:6];
      d.tag.sets_flags = 1'b1;
    end else begin
      case (instr[3:0])
        OP_LOAD: begin
          d.rd2_en       = 1'b1;
          d.tag.wr_valid = 1'b1;
          d.tag.wr_reg   = instr[7:6];
        end
        OP_STORE: begin
          d.rd1_en = 1'b1;
          d.rd2_en = 1'b1;
        end
        OP_ADD, OP_SUB, OP_NAND: begin
          d.rd1_en         = 1'b1;
          d.rd2_en         = 1'b1;
          d.tag.wr_valid   = 1'b1;
          d.tag.wr_reg     = instr[7:6];
          d.tag.sets_flags = 1'b1;
        end
        OP_BZ, OP_BNZ, OP_BPZ: d.is_branch = 1'b1;
        OP_STOP:               d.is_stop   = 1'b1;
        default:               ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight tag shift register with register/flag busy lookup
module hazard_scoreboard
  import proc_pkg::*;
#(
  parameter int NUM_SLOTS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  tag_t       shift_in,
  output logic [3:0] reg_busy,
  output logic       flag_busy,
  output logic       empty
);

  tag_t slot_q [NUM_SLOTS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      slot_q[0] <= shift_in;
      for (int i = 1; i < NUM_SLOTS; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  always_comb begin
    reg_busy  = '0;
    flag_busy = 1'b0;
    empty     = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q[i].wr_valid)   reg_busy[slot_q[i].wr_reg] = 1'b1;
      if (slot_q[i].sets_flags) flag_busy = 1'b1;
      if (slot_q[i] != '0)      empty = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - pipeline interlock, branch squash and STOP drain/halt sequencer
module hazard_control
  import proc_pkg::*;
#(
  parameter int NUM_SLOTS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IR1,
  input  logic       IR1Valid,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic       IR1Write,
  output logic       BubbleSel,
  output logic       FlushIR1,
  output logic       Stall,
  output logic       Halted
);

  state_t     state_q, state_d;
  dec_t       dec;
  tag_t       slot_in;
  logic [3:0] reg_busy;
  logic       flag_busy;
  logic       sb_empty;
  logic       hazard;

  assign dec = IR1Valid ? decode(IR1) : '0;

  assign hazard = (dec.rd1_en && reg_busy[dec.rd1_reg]) ||
                  (dec.rd2_en && reg_busy[dec.rd2_reg]) ||
                  (dec.is_branch && flag_busy);

  // Slot0 only records IR1 when it actually issues; every bubble enters as a zero tag
  assign slot_in = BubbleSel ? '0 : dec.tag;

  hazard_scoreboard #(.NUM_SLOTS(NUM_SLOTS)) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .shift_in  (slot_in),
    .reg_busy  (reg_busy),
    .flag_busy (flag_busy),
    .empty     (sb_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!BranchTaken && !hazard && dec.is_stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (BranchTaken)   state_d = ST_RUN;
        else if (sb_empty) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    IR1Write  = 1'b0;
    BubbleSel = 1'b1;
    FlushIR1  = 1'b0;
    Stall     = 1'b0;
    Halted    = 1'b0;
    if (reset) begin
      FlushIR1 = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (BranchTaken) begin
            FlushIR1 = 1'b1;
            PCWrite  = 1'b1;
            IR1Write = 1'b1;
          end else if (hazard) begin
            Stall = 1'b1;
          end else if (!dec.is_stop) begin
            PCWrite   = 1'b1;
            IR1Write  = 1'b1;
            BubbleSel = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (BranchTaken) begin
            FlushIR1 = 1'b1;
            PCWrite  = 1'b1;
            IR1Write = 1'b1;
          end
        end
        ST_HALTED: Halted = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - directed self-checking bench for hazard_control
module tb_hazard_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IR1 = 8'h00;
  logic       IR1Valid = 1'b0;
  logic       BranchTaken = 1'b0;
  logic       PCWrite, IR1Write, BubbleSel, FlushIR1, Stall, Halted;
  logic [5:0] outs;
  int         checks = 0;
  int         errors = 0;
  int         n;

  // {PCWrite, IR1Write, BubbleSel, FlushIR1, Stall, Halted}
  localparam logic [5:0] O_RESET  = 6'b001100;
  localparam logic [5:0] O_ISSUE  = 6'b110000;
  localparam logic [5:0] O_STALL  = 6'b001010;
  localparam logic [5:0] O_HOLD   = 6'b001000;
  localparam logic [5:0] O_BRANCH = 6'b111100;
  localparam logic [5:0] O_HALTED = 6'b001001;

  localparam logic [7:0] I_LOAD_R2  = 8'b10_11_0000;
  localparam logic [7:0] I_ADD_R1R2 = 8'b01_10_0100;
  localparam logic [7:0] I_ADD_R3R1 = 8'b11_01_0100;
  localparam logic [7:0] I_ADD_R3R0 = 8'b11_00_0100;
  localparam logic [7:0] I_ADD_R1R0 = 8'b01_00_0100;
  localparam logic [7:0] I_STORE    = 8'b01_10_0010;
  localparam logic [7:0] I_ORI      = 8'b00_00_0111;
  localparam logic [7:0] I_BZ       = 8'b00_00_0101;
  localparam logic [7:0] I_NOP      = 8'h0A;
  localparam logic [7:0] I_STOP     = 8'h01;

  assign outs = {PCWrite, IR1Write, BubbleSel, FlushIR1, Stall, Halted};

  hazard_control #(.NUM_SLOTS(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .IR1         (IR1),
    .IR1Valid    (IR1Valid),
    .BranchTaken (BranchTaken),
    .PCWrite     (PCWrite),
    .IR1Write    (IR1Write),
    .BubbleSel   (BubbleSel),
    .FlushIR1    (FlushIR1),
    .Stall       (Stall),
    .Halted      (Halted)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1);
  end

  task automatic drive(input logic [7:0] ir, input logic v, input logic br, input logic rst);
    @(negedge clock);
    IR1 = ir;
    IR1Valid = v;
    BranchTaken = br;
    reset = rst;
    #1;
  endtask

  task automatic count_stalls(input logic [7:0] ir, output int cnt);
    cnt = 0;
    drive(ir, 1'b1, 1'b0, 1'b0);
    while (Stall && cnt < 8) begin
      cnt++;
      drive(ir, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (outs !== O_RESET) begin errors++; $display("FAIL reset_outs got %b want %b", outs, O_RESET); end
    drive(I_LOAD_R2, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_ISSUE) begin errors++; $display("FAIL reset_load_issue got %b want %b", outs, O_ISSUE); end
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL pre_reset_stall got %b want %b", outs, O_STALL); end
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b1);
    checks++; if (outs !== O_RESET) begin errors++; $display("FAIL reset_mid_stall got %b want %b", outs, O_RESET); end
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_ISSUE) begin errors++; $display("FAIL post_reset_cleared got %b want %b", outs, O_ISSUE); end
  endtask

  task automatic test_raw;
    logic [5:0] exp;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_LOAD_R2, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_ISSUE) begin errors++; $display("FAIL raw_load_issue got %b want %b", outs, O_ISSUE); end
    for (int i = 0; i < 4; i++) begin
      drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
      exp = (i < 3) ? O_STALL : O_ISSUE;
      checks++; if (outs !== exp) begin errors++; $display("FAIL raw_cycle%0d got %b want %b", i, outs, exp); end
    end
  endtask

  task automatic test_partial;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
    drive(I_NOP, 1'b1, 1'b0, 1'b0);
    count_stalls(I_ADD_R3R1, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL partial_one_gap got %0d stalls want 2", n); end
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
    count_stalls(I_ADD_R3R0, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL partial_independent got %0d stalls want 0", n); end
  endtask

  task automatic test_flag;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_ORI, 1'b1, 1'b0, 1'b0);
    count_stalls(I_BZ, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL flag_ori_bz got %0d stalls want 3", n); end
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_STORE, 1'b1, 1'b0, 1'b0);
    count_stalls(I_BZ, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL flag_store_bz got %0d stalls want 0", n); end
  endtask

  task automatic test_branch_priority;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_LOAD_R2, 1'b1, 1'b0, 1'b0);
    drive(I_ADD_R1R2, 1'b1, 1'b1, 1'b0);
    checks++; if (outs !== O_BRANCH) begin errors++; $display("FAIL branch_over_hazard got %b want %b", outs, O_BRANCH); end
    // the squashed add must not have left an R1 writer in slot0
    count_stalls(I_ADD_R1R0, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL branch_slot0_zero got %0d stalls want 0", n); end
  endtask

  task automatic test_stop;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_STORE, 1'b1, 1'b0, 1'b0);
    drive(I_STOP, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_HOLD) begin errors++; $display("FAIL stop_issue got %b want %b", outs, O_HOLD); end
    drive(I_STOP, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_HOLD) begin errors++; $display("FAIL stop_drain got %b want %b", outs, O_HOLD); end
    for (int i = 0; i < 12; i++) begin
      drive(I_STOP, 1'b1, 1'b0, 1'b0);
      checks++; if (outs !== O_HALTED) begin errors++; $display("FAIL stop_halted_c%0d got %b want %b", i, outs, O_HALTED); end
    end
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (outs !== O_RESET) begin errors++; $display("FAIL halted_reset got %b want %b", outs, O_RESET); end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (outs !== O_ISSUE) begin errors++; $display("FAIL halted_reset_run got %b want %b", outs, O_ISSUE); end
  endtask

  task automatic test_drain_writer;
    logic [5:0] exp;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
    drive(I_STOP, 1'b1, 1'b0, 1'b0);
    checks++; if (outs !== O_HOLD) begin errors++; $display("FAIL drainw_stop got %b want %b", outs, O_HOLD); end
    for (int i = 0; i < 4; i++) begin
      drive(I_STOP, 1'b1, 1'b0, 1'b0);
      exp = (i < 3) ? O_HOLD : O_HALTED;
      checks++; if (outs !== exp) begin errors++; $display("FAIL drainw_c%0d got %b want %b", i, outs, exp); end
    end
  endtask

  task automatic test_drain_branch;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(I_ADD_R1R2, 1'b1, 1'b0, 1'b0);
    drive(I_STOP, 1'b1, 1'b0, 1'b0);
    drive(I_STOP, 1'b1, 1'b1, 1'b0);
    checks++; if (outs !== O_BRANCH) begin errors++; $display("FAIL drain_branch got %b want %b", outs, O_BRANCH); end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (outs !== O_ISSUE) begin errors++; $display("FAIL drain_branch_run got %b want %b", outs, O_ISSUE); end
    drive(I_STOP, 1'b1, 1'b0, 1'b0);
    drive(I_STOP, 1'b1, 1'b0, 1'b1);
    checks++; if (outs !== O_RESET) begin errors++; $display("FAIL reset_mid_drain got %b want %b", outs, O_RESET); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_partial();
    test_flag();
    test_branch_priority();
    test_stop();
    test_drain_writer();
    test_drain_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
